// File: rtl/shifter_seq.sv
// shifter_seq: iterative multi-bit shifter, one bit position per clock.
// Accepts an operand, shift amount and mode under a start/done handshake and
// supports LSL, LSR, ASR and ROR. The result register holds its value until
// the next operation completes or reset.
//
// Build option: define SHIFTER_SEQ_FLAGS_EN to add the cout/zflag outputs,
// which are updated together with sout.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   S_IDLE  | waiting for start; operands captured on start
//   S_SHIFT | shifting one bit per clock until the counter reaches zero
//   S_DONE  | one-cycle done pulse, sout valid; start ignored
module shifter_seq #(
  parameter int WIDTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  input  logic [AW-1:0]    amt,
  input  logic [1:0]       mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sout
`ifdef SHIFTER_SEQ_FLAGS_EN
  ,
  output logic             cout,
  output logic             zflag
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [1:0] MODE_LSL = 2'b00;
  localparam logic [1:0] MODE_LSR = 2'b01;
  localparam logic [1:0] MODE_ASR = 2'b10;
  localparam logic [1:0] MODE_ROR = 2'b11;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic [AW-1:0]    cnt_q,   cnt_d;
  logic [1:0]       mode_q,  mode_d;
  logic [WIDTH-1:0] sout_q,  sout_d;

  logic [WIDTH-1:0] data_shifted;
  logic             bit_out;

`ifdef SHIFTER_SEQ_FLAGS_EN
  // cry_q tracks the most recent bit pushed out; it is cleared on capture so
  // a zero-length shift reports cout=0.
  logic cry_q,   cry_d;
  logic cout_q,  cout_d;
  logic zflag_q, zflag_d;
`endif

  // Single-bit shift of the working data according to the captured mode.
  always_comb begin
    data_shifted = data_q;
    bit_out      = 1'b0;
    case (mode_q)
      MODE_LSL: begin
        data_shifted = {data_q[WIDTH-2:0], 1'b0};
        bit_out      = data_q[WIDTH-1];
      end
      MODE_LSR: begin
        data_shifted = {1'b0, data_q[WIDTH-1:1]};
        bit_out      = data_q[0];
      end
      MODE_ASR: begin
        data_shifted = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
        bit_out      = data_q[0];
      end
      MODE_ROR: begin
        data_shifted = {data_q[0], data_q[WIDTH-1:1]};
        bit_out      = data_q[0];
      end
      default: begin
        data_shifted = data_q;
        bit_out      = 1'b0;
      end
    endcase
  end

  // Next-state and datapath update for the handshake FSM.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    sout_d  = sout_q;
`ifdef SHIFTER_SEQ_FLAGS_EN
    cry_d   = cry_q;
    cout_d  = cout_q;
    zflag_d = zflag_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          data_d  = in;
          cnt_d   = amt;
          mode_d  = mode;
          state_d = S_SHIFT;
`ifdef SHIFTER_SEQ_FLAGS_EN
          cry_d   = 1'b0;
`endif
        end
      end
      S_SHIFT: begin
        if (cnt_q == '0) begin
          sout_d  = data_q;
          state_d = S_DONE;
`ifdef SHIFTER_SEQ_FLAGS_EN
          cout_d  = cry_q;
          zflag_d = (data_q == '0);
`endif
        end else begin
          data_d = data_shifted;
          cnt_d  = cnt_q - AW'(1);
`ifdef SHIFTER_SEQ_FLAGS_EN
          cry_d  = bit_out;
`endif
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      mode_q  <= MODE_LSL;
      sout_q  <= '0;
`ifdef SHIFTER_SEQ_FLAGS_EN
      cry_q   <= 1'b0;
      cout_q  <= 1'b0;
      zflag_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      sout_q  <= sout_d;
`ifdef SHIFTER_SEQ_FLAGS_EN
      cry_q   <= cry_d;
      cout_q  <= cout_d;
      zflag_q <= zflag_d;
`endif
    end
  end

  assign busy = (state_q == S_SHIFT);
  assign done = (state_q == S_DONE);
  assign sout = sout_q;

`ifdef SHIFTER_SEQ_FLAGS_EN
  assign cout  = cout_q;
  assign zflag = zflag_q;
`endif

endmodule

// File: tb/tb_shifter_seq.sv
// Testbench for shifter_seq (WIDTH=16): directed cases followed by random
// operations, compared against an arithmetic reference of the shift rules.
module tb_shifter_seq;

  localparam int W = 16;

  logic          clk;
  logic          reset_n;
  logic          start;
  logic [W-1:0]  in_i;
  logic [3:0]    amt_i;
  logic [1:0]    mode_i;
  logic          busy;
  logic          done;
  logic [W-1:0]  sout;
`ifdef SHIFTER_SEQ_FLAGS_EN
  logic          cout;
  logic          zflag;
`endif

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  logic [W-1:0] prev_sout;

  shifter_seq #(.WIDTH(W), .AW(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .in      (in_i),
    .amt     (amt_i),
    .mode    (mode_i),
    .busy    (busy),
    .done    (done),
    .sout    (sout)
`ifdef SHIFTER_SEQ_FLAGS_EN
    ,
    .cout    (cout),
    .zflag   (zflag)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: whole-amount shift computed directly from the mode rules.
  function automatic logic [W-1:0] ref_shift(input logic [W-1:0] a, input int s, input logic [1:0] m);
    logic [2*W-1:0] dbl;
    logic signed [W-1:0] sa;
    case (m)
      2'b00: return a << s;
      2'b01: return a >> s;
      2'b10: begin
        sa = a;
        return sa >>> s;
      end
      default: begin
        dbl = {a, a};
        dbl = dbl >> s;
        return dbl[W-1:0];
      end
    endcase
  endfunction

  function automatic logic ref_cout(input logic [W-1:0] a, input int s, input logic [1:0] m);
    if (s == 0) return 1'b0;
    if (m == 2'b00) return a[W-s];
    return a[s-1];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Counts rising edges until done is seen; gives up after 40 edges.
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  // One complete operation with latency, busy, hold and result checks.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [3:0] s,
                        input logic [1:0] m, input bit repulse);
    int lat;
    int busy_n;
    bit held;
    logic [W-1:0] exp;
    @(negedge clk);
    in_i = a; amt_i = s; mode_i = m; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    in_i = W'($urandom); amt_i = 4'($urandom); mode_i = 2'($urandom);
    lat = 0; busy_n = 0; held = 1'b1;
    while (!done && lat < 40) begin
      if (busy) busy_n++;
      if (sout !== prev_sout) held = 1'b0;
      if (repulse && lat == 1) begin
        start = 1'b1; in_i = ~a; amt_i = s ^ 4'd1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    exp = ref_shift(a, int'(s), m);
    check({tag, "_latency"}, 32'(lat), 32'(s) + 32'd1);
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'(s) + 32'd1);
    check({tag, "_sout_held"}, 32'(held), 32'd1);
    check({tag, "_sout"}, 32'(sout), 32'(exp));
    check({tag, "_busy_in_done"}, 32'(busy), 32'd0);
`ifdef SHIFTER_SEQ_FLAGS_EN
    check({tag, "_cout"}, 32'(cout), 32'(ref_cout(a, int'(s), m)));
    check({tag, "_zflag"}, 32'(zflag), 32'(exp == '0));
`endif
    @(posedge clk); #1;
    check({tag, "_done_pulse_end"}, 32'(done), 32'd0);
    prev_sout = exp;
  endtask

  initial begin
    int n;
    int pulses;
    logic [W-1:0] a;
    logic [3:0]   s;
    logic [1:0]   m;

    reset_n = 1'b0; start = 1'b0; in_i = '0; amt_i = '0; mode_i = '0;
    prev_sout = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_sout", 32'(sout), 32'd0);
`ifdef SHIFTER_SEQ_FLAGS_EN
    check("reset_cout", 32'(cout), 32'd0);
    check("reset_zflag", 32'(zflag), 32'd0);
`endif
    @(negedge clk);
    reset_n = 1'b1;

    run_op("lsl_f00f_4", 16'hF00F, 4'd4, 2'b00, 1'b0);
    check("lsl_f00f_4_value", 32'(sout), 32'h00F0);
    run_op("lsr_f00f_4", 16'hF00F, 4'd4, 2'b01, 1'b0);
    check("lsr_f00f_4_value", 32'(sout), 32'h0F00);
    run_op("asr_f00f_4", 16'hF00F, 4'd4, 2'b10, 1'b0);
    check("asr_f00f_4_value", 32'(sout), 32'hFF00);
    run_op("asr_8002_2", 16'h8002, 4'd2, 2'b10, 1'b0);
    check("asr_8002_2_value", 32'(sout), 32'hE000);
    run_op("ror_8002_2", 16'h8002, 4'd2, 2'b11, 1'b0);
    check("ror_8002_2_value", 32'(sout), 32'hA000);
    for (int mm = 0; mm < 4; mm++) begin
      run_op("amt0", 16'h1234, 4'd0, 2'(mm), 1'b0);
      check("amt0_value", 32'(sout), 32'h1234);
    end
    run_op("lsr_0001_1", 16'h0001, 4'd1, 2'b01, 1'b0);
    check("lsr_0001_1_value", 32'(sout), 32'h0000);
    run_op("ror_max", 16'hC351, 4'd15, 2'b11, 1'b0);

    // start re-pulsed while busy must not spawn a second operation
    run_op("repulse", 16'h1357, 4'd6, 2'b00, 1'b1);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done || busy) pulses++;
    end
    check("repulse_no_second_op", 32'(pulses), 32'd0);
    check("repulse_result_kept", 32'(sout), 32'(ref_shift(16'h1357, 6, 2'b00)));

    // start held high: a second operation is taken on return to IDLE
    @(negedge clk);
    in_i = 16'h00F1; amt_i = 4'd1; mode_i = 2'b01; start = 1'b1;
    @(posedge clk); #1;
    wait_done(n);
    check("hold_first_latency", 32'(n), 32'd2);
    check("hold_first_sout", 32'(sout), 32'(ref_shift(16'h00F1, 1, 2'b01)));
    in_i = 16'h9001; amt_i = 4'd2; mode_i = 2'b11;
    @(posedge clk); #1;
    wait_done(n);
    check("hold_second_gap", 32'(n), 32'd4);
    check("hold_second_sout", 32'(sout), 32'(ref_shift(16'h9001, 2, 2'b11)));
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    prev_sout = sout;

    // reset in the middle of a long shift discards the operation
    @(negedge clk);
    in_i = 16'hBEEF; amt_i = 4'd15; mode_i = 2'b10; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk); #1;
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_done", 32'(done), 32'd0);
    check("midreset_sout", 32'(sout), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    prev_sout = '0;
    run_op("after_reset_lsl", 16'h0001, 4'd15, 2'b00, 1'b0);
    check("after_reset_lsl_value", 32'(sout), 32'h8000);

    for (int i = 0; i < 30; i++) begin
      a = W'($urandom);
      s = 4'($urandom_range(0, 15));
      m = 2'($urandom_range(0, 3));
      run_op("random", a, s, m, 1'b0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
